// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - state codes, light codes and duration selection for the intersection controller
package tlc_pkg;

  typedef enum logic [3:0] {
    ST_ALL_RED   = 4'd0,
    ST_PED_WALK  = 4'd1,
    ST_NS_GREEN  = 4'd2,
    ST_NS_YELLOW = 4'd3,
    ST_EW_GREEN  = 4'd4,
    ST_EW_YELLOW = 4'd5
  } state_e;

  typedef enum logic [1:0] {
    DUR_ALLRED = 2'd0,
    DUR_PED    = 2'd1,
    DUR_GREEN  = 2'd2,
    DUR_YELLOW = 2'd3
  } dur_e;

  localparam logic [2:0] LIGHT_GREEN  = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b001;

  localparam logic [1:0] PED_NONE = 2'b00;
  localparam logic [1:0] PED_NS   = 2'b10;
  localparam logic [1:0] PED_EW   = 2'b01;
  localparam logic [1:0] PED_BOTH = 2'b11;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  // Illegal codes fall back to the all-red duration, matching their recovery state.
  function automatic dur_e duration_select(input state_e s);
    case (s)
      ST_PED_WALK:               return DUR_PED;
      ST_NS_GREEN, ST_EW_GREEN:  return DUR_GREEN;
      ST_NS_YELLOW, ST_EW_YELLOW: return DUR_YELLOW;
      default:                   return DUR_ALLRED;
    endcase
  endfunction

endpackage

// File: rtl/tlc_tick_timer.sv
// rtl/tlc_tick_timer.sv - loadable down-counter stepped by the time-base strobe
module tlc_tick_timer #(
  parameter int unsigned TW      = 5,
  parameter int unsigned RST_VAL = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          tick_i,
  output logic [TW-1:0] count_o,
  output logic          expire_o
);

  localparam logic [TW-1:0] ONE = TW'(1);
  localparam logic [TW-1:0] RST = TW'(RST_VAL);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= RST;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = tick_i && (count_q == ONE);

endmodule

// File: rtl/tlc_param_controller.sv
// rtl/tlc_param_controller.sv - four-way controller with green extension, all-red clearance and ped walk
module tlc_param_controller
  import tlc_pkg::*;
#(
  parameter int unsigned TW          = 5,
  parameter int unsigned T_GREEN     = 10,
  parameter int unsigned T_GREEN_MAX = 20,
  parameter int unsigned T_YELLOW    = 5,
  parameter int unsigned T_ALLRED    = 1,
  parameter int unsigned T_PED       = 15
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          tick_i,
  input  logic          car_ns_i,
  input  logic          car_ew_i,
  input  logic          ped_req_i,
  output logic [2:0]    light_ns_o,
  output logic [2:0]    light_ew_o,
  output logic [1:0]    light_ped_o,
  output logic          ped_pending_o,
  output logic [3:0]    state_out_o,
  output logic [TW-1:0] timer_out_o
);

  localparam logic [TW-1:0] ONE      = TW'(1);
  localparam logic [TW-1:0] D_GREEN  = TW'(T_GREEN);
  localparam logic [TW-1:0] D_GMAX   = TW'(T_GREEN_MAX);
  localparam logic [TW-1:0] D_YELLOW = TW'(T_YELLOW);
  localparam logic [TW-1:0] D_ALLRED = TW'(T_ALLRED);
  localparam logic [TW-1:0] D_PED    = TW'(T_PED);

  state_e        state_q, state_d;
  logic          next_dir_q, next_dir_d;
  logic          ped_pending_q, ped_pending_d;
  logic [TW-1:0] elapsed_q, elapsed_d;
  logic          pick_dir, extend, load;
  logic [TW-1:0] load_val, count;
  logic          expire;
  state_e        green_st;

  tlc_tick_timer #(.TW(TW), .RST_VAL(T_ALLRED)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (load),
    .load_val_i (load_val),
    .tick_i     (tick_i),
    .count_o    (count),
    .expire_o   (expire)
  );

  always_comb begin
    state_d       = state_q;
    next_dir_d    = next_dir_q;
    elapsed_d     = elapsed_q;
    ped_pending_d = ped_pending_q | ped_req_i;
    extend        = 1'b0;

    if (car_ns_i && !car_ew_i)      pick_dir = DIR_NS;
    else if (!car_ns_i && car_ew_i) pick_dir = DIR_EW;
    else                            pick_dir = next_dir_q;
    green_st = (pick_dir == DIR_NS) ? ST_NS_GREEN : ST_EW_GREEN;

    case (state_q)
      ST_ALL_RED:   if (expire) state_d = (ped_pending_q || ped_req_i) ? ST_PED_WALK : green_st;
      ST_PED_WALK:  if (expire) state_d = green_st;
      ST_NS_GREEN: begin
        if (expire) begin
          if (car_ns_i && !car_ew_i && !ped_pending_q && (elapsed_q < D_GMAX)) extend = 1'b1;
          else state_d = ST_NS_YELLOW;
        end
      end
      ST_EW_GREEN: begin
        if (expire) begin
          if (car_ew_i && !car_ns_i && !ped_pending_q && (elapsed_q < D_GMAX)) extend = 1'b1;
          else state_d = ST_EW_YELLOW;
        end
      end
      ST_NS_YELLOW: if (expire) state_d = ST_ALL_RED;
      ST_EW_YELLOW: if (expire) state_d = ST_ALL_RED;
      default:      state_d = ST_ALL_RED;
    endcase

    if (extend) elapsed_d = elapsed_q + ONE;

    // Entering a green hands priority to the other direction for the next undecided choice.
    if ((state_d != state_q) && ((state_d == ST_NS_GREEN) || (state_d == ST_EW_GREEN))) begin
      next_dir_d = (state_d == ST_NS_GREEN) ? DIR_EW : DIR_NS;
      elapsed_d  = D_GREEN;
    end
    if ((state_d == ST_PED_WALK) && (state_q != ST_PED_WALK)) ped_pending_d = 1'b0;

    load     = extend || (state_d != state_q);
    load_val = D_ALLRED;
    if (extend) begin
      load_val = ONE;
    end else begin
      case (duration_select(state_d))
        DUR_PED:    load_val = D_PED;
        DUR_GREEN:  load_val = D_GREEN;
        DUR_YELLOW: load_val = D_YELLOW;
        default:    load_val = D_ALLRED;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_ALL_RED;
      next_dir_q    <= DIR_NS;
      ped_pending_q <= 1'b0;
      elapsed_q     <= '0;
    end else begin
      state_q       <= state_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
      elapsed_q     <= elapsed_d;
    end
  end

  always_comb begin
    light_ns_o  = LIGHT_RED;
    light_ew_o  = LIGHT_RED;
    light_ped_o = PED_NONE;
    case (state_q)
      ST_PED_WALK:  light_ped_o = PED_BOTH;
      ST_NS_GREEN:  begin light_ns_o = LIGHT_GREEN;  light_ped_o = PED_NS; end
      ST_NS_YELLOW: begin light_ns_o = LIGHT_YELLOW; light_ped_o = PED_NS; end
      ST_EW_GREEN:  begin light_ew_o = LIGHT_GREEN;  light_ped_o = PED_EW; end
      ST_EW_YELLOW: begin light_ew_o = LIGHT_YELLOW; light_ped_o = PED_EW; end
      default:      light_ped_o = PED_NONE;
    endcase
  end

  assign ped_pending_o = ped_pending_q;
  assign state_out_o   = state_q;
  assign timer_out_o   = count;

endmodule

// File: tb/tb_tlc_param_controller.sv
// tb/tb_tlc_param_controller.sv - directed and random checks of the controller against a tick-level model
module tb_tlc_param_controller;
  import tlc_pkg::*;

  localparam int TW = 5, TG = 10, TGM = 20, TY = 5, TAR = 1, TP = 15;

  logic          clk = 1'b0;
  logic          rst_n, tick, car_ns, car_ew, ped_req;
  logic [2:0]    light_ns, light_ew;
  logic [1:0]    light_ped;
  logic          ped_pending;
  logic [3:0]    state_out;
  logic [TW-1:0] timer_out;

  always #5 clk = ~clk;

  tlc_param_controller #(
    .TW(TW), .T_GREEN(TG), .T_GREEN_MAX(TGM), .T_YELLOW(TY), .T_ALLRED(TAR), .T_PED(TP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .car_ns_i(car_ns), .car_ew_i(car_ew),
    .ped_req_i(ped_req), .light_ns_o(light_ns), .light_ew_o(light_ew), .light_ped_o(light_ped),
    .ped_pending_o(ped_pending), .state_out_o(state_out), .timer_out_o(timer_out)
  );

  int n_cmp = 0;
  int n_err = 0;

  state_e m_state;
  int     m_left, m_gticks;
  bit     m_dir_ns, m_ped;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dur(input state_e s);
    case (s)
      ST_PED_WALK:                return TP;
      ST_NS_GREEN, ST_EW_GREEN:   return TG;
      ST_NS_YELLOW, ST_EW_YELLOW: return TY;
      default:                    return TAR;
    endcase
  endfunction

  task automatic model_reset();
    m_state = ST_ALL_RED; m_left = TAR; m_dir_ns = 1'b1; m_ped = 1'b0; m_gticks = 0;
  endtask

  task automatic model_enter(input state_e s);
    m_state = s;
    m_left  = dur(s);
    if (s == ST_NS_GREEN || s == ST_EW_GREEN) begin
      m_gticks = 0;
      m_dir_ns = (s == ST_EW_GREEN);
    end
  endtask

  task automatic model_step();
    bit ped_in, pick_ns, walk_entry;
    state_e pick;
    walk_entry = 1'b0;
    ped_in  = m_ped | ped_req;
    pick_ns = (car_ns && !car_ew) ? 1'b1 : ((!car_ns && car_ew) ? 1'b0 : m_dir_ns);
    pick    = pick_ns ? ST_NS_GREEN : ST_EW_GREEN;
    if (tick) begin
      if (m_state == ST_NS_GREEN || m_state == ST_EW_GREEN) m_gticks++;
      if (m_left > 1) m_left--;
      else begin
        case (m_state)
          ST_ALL_RED:   if (ped_in) begin model_enter(ST_PED_WALK); walk_entry = 1'b1; end
                        else model_enter(pick);
          ST_PED_WALK:  model_enter(pick);
          ST_NS_GREEN:  if (car_ns && !car_ew && !m_ped && m_gticks < TGM) m_left = 1;
                        else model_enter(ST_NS_YELLOW);
          ST_EW_GREEN:  if (car_ew && !car_ns && !m_ped && m_gticks < TGM) m_left = 1;
                        else model_enter(ST_EW_YELLOW);
          default:      model_enter(ST_ALL_RED);
        endcase
      end
    end
    m_ped = walk_entry ? 1'b0 : ped_in;
  endtask

  task automatic compare_all();
    logic [2:0] ens, eew;
    logic [1:0] eped;
    ens = 3'b001; eew = 3'b001; eped = 2'b00;
    case (m_state)
      ST_PED_WALK:  eped = 2'b11;
      ST_NS_GREEN:  begin ens = 3'b100; eped = 2'b10; end
      ST_NS_YELLOW: begin ens = 3'b010; eped = 2'b10; end
      ST_EW_GREEN:  begin eew = 3'b100; eped = 2'b01; end
      ST_EW_YELLOW: begin eew = 3'b010; eped = 2'b01; end
      default:      eped = 2'b00;
    endcase
    check("model_state", 32'(state_out), 32'(m_state));
    check("model_timer", 32'(timer_out), 32'(m_left));
    check("model_light_ns", 32'(light_ns), 32'(ens));
    check("model_light_ew", 32'(light_ew), 32'(eew));
    check("model_light_ped", 32'(light_ped), 32'(eped));
    check("model_ped_pending", 32'(ped_pending), 32'(m_ped));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic run_phase(input string tag, input state_e s, input int exp_len);
    int n;
    n = 0;
    check({tag, "_state"}, 32'(state_out), 32'(s));
    while (state_out == 4'(s) && n < 64) begin
      tick_pulse();
      n++;
    end
    check({tag, "_len"}, 32'(n), 32'(exp_len));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; tick = 1'b0; car_ns = 1'b0; car_ew = 1'b0; ped_req = 1'b0;
    model_reset();
    repeat (3) step();
    check("rst_state", 32'(state_out), 32'(ST_ALL_RED));
    check("rst_timer", 32'(timer_out), 32'd1);
    check("rst_light_ns", 32'(light_ns), 32'b001);
    check("rst_light_ew", 32'(light_ew), 32'b001);
    check("rst_light_ped", 32'(light_ped), 32'b00);
    rst_n = 1'b1;
    step();

    tick_pulse();
    check("first_green_state", 32'(state_out), 32'(ST_NS_GREEN));
    check("first_green_light_ns", 32'(light_ns), 32'b100);
    check("first_green_timer", 32'(timer_out), 32'd10);
    tick_pulse();
    check("second_tick_timer", 32'(timer_out), 32'd9);

    run_phase("free_ns_green", ST_NS_GREEN, 9);
    run_phase("free_ns_yellow", ST_NS_YELLOW, 5);
    run_phase("free_all_red1", ST_ALL_RED, 1);
    run_phase("free_ew_green", ST_EW_GREEN, 10);
    run_phase("free_ew_yellow", ST_EW_YELLOW, 5);
    car_ns = 1'b1;
    run_phase("free_all_red2", ST_ALL_RED, 1);
    run_phase("ext_max_green", ST_NS_GREEN, 20);
    car_ns = 1'b0;
    run_phase("ext_max_yellow", ST_NS_YELLOW, 5);
    car_ns = 1'b1;
    run_phase("dirsel_all_red", ST_ALL_RED, 1);

    check("cut_state", 32'(state_out), 32'(ST_NS_GREEN));
    n = 0;
    while (state_out == 4'(ST_NS_GREEN) && n < 13) begin tick_pulse(); n++; end
    check("cut_still_green", 32'(state_out), 32'(ST_NS_GREEN));
    car_ew = 1'b1;
    while (state_out == 4'(ST_NS_GREEN) && n < 64) begin tick_pulse(); n++; end
    check("cut_green_len", 32'(n), 32'd14);
    car_ns = 1'b0; car_ew = 1'b0;
    run_phase("cut_yellow", ST_NS_YELLOW, 5);
    car_ns = 1'b1;
    run_phase("ped_pre_all_red", ST_ALL_RED, 1);

    n = 0;
    repeat (3) begin tick_pulse(); n++; end
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    check("ped_latched", 32'(ped_pending), 32'd1);
    while (state_out == 4'(ST_NS_GREEN) && n < 64) begin tick_pulse(); n++; end
    check("ped_no_ext_len", 32'(n), 32'd10);
    car_ns = 1'b0;
    run_phase("ped_yellow", ST_NS_YELLOW, 5);
    run_phase("ped_all_red", ST_ALL_RED, 1);
    check("walk_light_ped", 32'(light_ped), 32'b11);
    check("walk_pending_clr", 32'(ped_pending), 32'd0);
    run_phase("walk", ST_PED_WALK, 15);
    check("after_walk_state", 32'(state_out), 32'(ST_EW_GREEN));

    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    run_phase("coin_ew_green", ST_EW_GREEN, 10);
    run_phase("coin_ew_yellow", ST_EW_YELLOW, 5);
    tick = 1'b1; ped_req = 1'b1;
    step();
    tick = 1'b0; ped_req = 1'b0;
    check("coin_walk_state", 32'(state_out), 32'(ST_PED_WALK));
    check("coin_pending_clr", 32'(ped_pending), 32'd0);
    step();
    check("coin_pending_stays", 32'(ped_pending), 32'd0);

    for (int i = 0; i < 800; i++) begin
      if (i % 16 == 0) begin
        car_ns = 1'($urandom_range(0, 1));
        car_ew = 1'($urandom_range(0, 1));
      end
      tick    = ($urandom_range(0, 1) == 0);
      ped_req = ($urandom_range(0, 39) == 0);
      step();
    end
    tick = 1'b0; car_ns = 1'b0; car_ew = 1'b0; ped_req = 1'b0;

    n = 0;
    while (state_out != 4'(ST_EW_YELLOW) && n < 300) begin tick_pulse(); n++; end
    check("reach_ew_yellow", 32'(state_out), 32'(ST_EW_YELLOW));
    rst_n = 1'b0;
    #1;
    check("async_rst_light_ew", 32'(light_ew), 32'b001);
    check("async_rst_state", 32'(state_out), 32'(ST_ALL_RED));
    check("async_rst_timer", 32'(timer_out), 32'd1);
    check("async_rst_pending", 32'(ped_pending), 32'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    step();
    tick_pulse();
    check("post_rst_green", 32'(state_out), 32'(ST_NS_GREEN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
